// File: rtl/alu_seq.sv
// Sequential ALU with start/done handshake; mul is shift-add and div/mod are restoring, each one step per cycle.
// `ALU_SEQ_MULDIV_EN enables the MUL/DIV states. Without it, opcodes 00100-01000 report error on the 1-cycle path.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       opCode,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataC,
  output logic             zero,
  output logic             overflow,
  output logic             error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd1
`ifdef ALU_SEQ_MULDIV_EN
    ,
    MUL  = 2'd2,
    DIV  = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dataC_q, dataC_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf, sc_err;
  logic [WIDTH:0]   add_w, sub_w;

  assign add_w = {1'b0, dataA} + {1'b0, dataB};
  assign sub_w = {1'b0, dataA} - {1'b0, dataB};

`ifdef ALU_SEQ_MULDIV_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               mod_q, mod_d;
  logic               sc_long;

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  logic [WIDTH:0]     mul_sum, div_sh, div_sub;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt;
  logic               div_ge;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_sub = div_sh - {1'b0, b_q};
  assign div_ge  = div_sh >= {1'b0, b_q};
  assign div_nxt = {(div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
`endif

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_err = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
    sc_long = 1'b0;
`endif
    case (opCode)
      5'b00000, 5'b00001: begin sc_res = add_w[WIDTH-1:0]; sc_ovf = add_w[WIDTH]; end
      5'b00010, 5'b00011: begin sc_res = sub_w[WIDTH-1:0]; sc_ovf = sub_w[WIDTH]; end
`ifdef ALU_SEQ_MULDIV_EN
      5'b00100, 5'b00101: sc_long = 1'b1;
      5'b00110, 5'b00111, 5'b01000: begin
        if (dataB == '0) sc_err = 1'b1;
        else             sc_long = 1'b1;
      end
`endif
      5'b01001, 5'b01010: sc_res = WIDTH'(dataA < dataB);
      5'b10010, 5'b10011: sc_res = WIDTH'(dataA > dataB);
      5'b01011, 5'b01100: sc_res = dataA & dataB;
      5'b01101, 5'b01110: sc_res = dataA | dataB;
      5'b01111:           sc_res = ~dataA;
      5'b10000:           sc_res = (dataB >= WIDTH'(WIDTH)) ? '0 : dataA >> dataB;
      5'b10001:           sc_res = (dataB >= WIDTH'(WIDTH)) ? '0 : dataA << dataB;
      default:            sc_err = 1'b1;
    endcase
    sc_err = sc_err | sc_ovf;
  end

  always_comb begin
    state_d = state_q;
    dataC_d = dataC_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
`ifdef ALU_SEQ_MULDIV_EN
    cnt_d = cnt_q;
    acc_d = acc_q;
    a_d   = a_q;
    b_d   = b_q;
    mod_d = mod_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef ALU_SEQ_MULDIV_EN
          a_d   = dataA;
          b_d   = dataB;
          mod_d = (opCode == 5'b01000);
          if (sc_long) begin
            cnt_d = CW'(WIDTH);
            if (opCode[4:1] == 4'b0010) begin
              state_d = MUL;
              acc_d   = {{WIDTH{1'b0}}, dataB};
            end else begin
              state_d = DIV;
              acc_d   = {{WIDTH{1'b0}}, dataA};
            end
          end else
`endif
          begin
            state_d = DONE;
            dataC_d = sc_res;
            zero_d  = (sc_res == '0);
            ovf_d   = sc_ovf;
            err_d   = sc_err;
          end
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          dataC_d = mul_nxt[WIDTH-1:0];
          zero_d  = (mul_nxt[WIDTH-1:0] == '0);
          ovf_d   = |mul_nxt[2*WIDTH-1:WIDTH];
          err_d   = |mul_nxt[2*WIDTH-1:WIDTH];
        end
      end
      DIV: begin
        acc_d = div_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          dataC_d = mod_q ? div_nxt[2*WIDTH-1:WIDTH] : div_nxt[WIDTH-1:0];
          zero_d  = mod_q ? (div_nxt[2*WIDTH-1:WIDTH] == '0) : (div_nxt[WIDTH-1:0] == '0);
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dataC_q <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mod_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dataC_q <= dataC_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
`ifdef ALU_SEQ_MULDIV_EN
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mod_q   <= mod_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign dataC    = dataC_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign error    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed table-driven bench for alu_seq at WIDTH=32, plus busy-start and mid-operation reset sequences.
module tb_alu_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  opCode = '0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic        busy, done, zero, overflow, error;
  logic [31:0] dataC;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .opCode(opCode),
    .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
    .dataC(dataC), .zero(zero), .overflow(overflow), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        o;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic o, input logic e, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.c = c; v.o = o; v.e = e; v.lat = lat;
`ifndef ALU_SEQ_MULDIV_EN
    // without the mul/div datapath these opcodes are reported as illegal
    if (op >= 5'd4 && op <= 5'd8) begin
      v.c = '0; v.o = 1'b0; v.e = 1'b1; v.lat = 1;
    end
`endif
    return v;
  endfunction

  // Launch one op; while busy either idle the inputs or keep hammering start with junk.
  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input bit noisy, output int lat);
    bit ok;
    @(negedge clock);
    opCode = op; dataA = a; dataB = b; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    opCode = 5'($urandom); dataA = $urandom; dataB = $urandom;
    chk("busy_rise", 32'(busy), 32'd1);
    lat = 0;
    ok = 1'b0;
    while (lat < 200) begin
      @(negedge clock);
      lat++;
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (noisy) begin
        start = 1'b1;
        opCode = 5'($urandom); dataA = $urandom; dataB = $urandom;
      end
    end
    start = 1'b0;
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int seen;

    vecs.push_back(mk(5'b00000, 32'hFFFF_FFFF, 32'd1,        32'd0,          1, 1, 1));
    vecs.push_back(mk(5'b00001, 32'd5,         32'd7,        32'd12,         0, 0, 1));
    vecs.push_back(mk(5'b00010, 32'd3,         32'd5,        32'hFFFF_FFFE,  1, 1, 1));
    vecs.push_back(mk(5'b00011, 32'd10,        32'd3,        32'd7,          0, 0, 1));
    vecs.push_back(mk(5'b00100, 32'h0001_0000, 32'h0001_0000, 32'd0,         1, 1, 33));
    vecs.push_back(mk(5'b00101, 32'd7,         32'd6,        32'd42,         0, 0, 33));
    vecs.push_back(mk(5'b00100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1, 1, 33));
    vecs.push_back(mk(5'b00101, 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, 0, 0, 33));
    vecs.push_back(mk(5'b00110, 32'd100,       32'd7,        32'd14,         0, 0, 33));
    vecs.push_back(mk(5'b01000, 32'd100,       32'd7,        32'd2,          0, 0, 33));
    vecs.push_back(mk(5'b00111, 32'd5,         32'd0,        32'd0,          0, 1, 1));
    vecs.push_back(mk(5'b01000, 32'd9,         32'd0,        32'd0,          0, 1, 1));
    vecs.push_back(mk(5'b00110, 32'd3,         32'd10,       32'd0,          0, 0, 33));
    vecs.push_back(mk(5'b00111, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF,  0, 0, 33));
    vecs.push_back(mk(5'b01000, 32'hFFFF_FFFF, 32'd16,       32'd15,         0, 0, 33));
    vecs.push_back(mk(5'b01001, 32'd3,         32'd5,        32'd1,          0, 0, 1));
    vecs.push_back(mk(5'b01010, 32'd5,         32'd3,        32'd0,          0, 0, 1));
    vecs.push_back(mk(5'b10010, 32'd5,         32'd3,        32'd1,          0, 0, 1));
    vecs.push_back(mk(5'b10011, 32'd3,         32'd3,        32'd0,          0, 0, 1));
    vecs.push_back(mk(5'b01011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, 0, 1));
    vecs.push_back(mk(5'b01100, 32'hF0F0_0000, 32'hFF00_0000, 32'hF000_0000, 0, 0, 1));
    vecs.push_back(mk(5'b01101, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 0, 0, 1));
    vecs.push_back(mk(5'b01110, 32'h8000_0000, 32'd1,        32'h8000_0001,  0, 0, 1));
    vecs.push_back(mk(5'b01111, 32'd0,         32'd9,        32'hFFFF_FFFF,  0, 0, 1));
    vecs.push_back(mk(5'b01111, 32'hFFFF_FFFF, 32'd0,        32'd0,          0, 0, 1));
    vecs.push_back(mk(5'b10000, 32'h0000_00F0, 32'd40,       32'd0,          0, 0, 1));
    vecs.push_back(mk(5'b10000, 32'h0000_00F0, 32'd4,        32'h0000_000F,  0, 0, 1));
    vecs.push_back(mk(5'b10000, 32'h8000_0000, 32'd31,       32'd1,          0, 0, 1));
    vecs.push_back(mk(5'b10001, 32'd1,         32'd31,       32'h8000_0000,  0, 0, 1));
    vecs.push_back(mk(5'b10001, 32'd1,         32'd32,       32'd0,          0, 0, 1));
    vecs.push_back(mk(5'b10111, 32'd4,         32'd4,        32'd0,          0, 1, 1));
    vecs.push_back(mk(5'b10100, 32'd1,         32'd2,        32'd0,          0, 1, 1));
    vecs.push_back(mk(5'b11111, 32'd7,         32'd7,        32'd0,          0, 1, 1));

    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dataC", dataC, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_busy", 32'(busy), 32'd0);

    foreach (vecs[i]) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, (i % 3) == 1, lat);
      chk($sformatf("v%0d_lat", i),  32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_dataC", i), dataC, vecs[i].c);
      chk($sformatf("v%0d_zero", i),  32'(zero), 32'(vecs[i].c == 32'd0));
      chk($sformatf("v%0d_ovf", i),   32'(overflow), 32'(vecs[i].o));
      chk($sformatf("v%0d_err", i),   32'(error), 32'(vecs[i].e));
      @(negedge clock);
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_busy_low", i),   32'(busy), 32'd0);
      chk($sformatf("v%0d_hold", i),       dataC, vecs[i].c);
    end

    // Back-to-back: start again in the first cycle after done
    run(5'b00000, 32'd1, 32'd2, 1'b0, lat);
    run(5'b00010, 32'd3, 32'd5, 1'b0, lat);
    chk("b2b_lat", 32'(lat), 32'd1);
    chk("b2b_dataC", dataC, 32'hFFFF_FFFE);

    // Reset in flight: no done pulse, everything back to zero
    @(negedge clock);
    opCode = 5'b00110; dataA = 32'd100; dataB = 32'd7; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
    repeat (10) @(negedge clock);
    chk("midop_busy", 32'(busy), 32'd1);
    chk("midop_hold", dataC, 32'hFFFF_FFFE);
`endif
    reset = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_dataC", dataC, 32'd0);
    chk("mrst_zero", 32'(zero), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    chk("mrst_err", 32'(error), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen++;
    end
    chk("mrst_no_done", 32'(seen), 32'd0);
    chk("mrst_idle", 32'(busy), 32'd0);

    run(5'b00001, 32'd5, 32'd7, 1'b0, lat);
    chk("post_rst_dataC", dataC, 32'd12);
    chk("post_rst_lat", 32'(lat), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the core's combinational ALU. It keeps the same 5-bit opcode map and adds a clock, a start/done handshake, registered results and a WIDTH parameter. Multiply, divide and modulo run iteratively: shift-add for multiply, restoring division for divide and modulo. The block sits in the execute stage, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand/result width in bits, must be ≥ 4.
- `clock`  in  1: single clock; every register updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; accepted only when `busy`=0.
- `opCode`  in  5: operation, sampled with `start`.
- `dataA`  in  WIDTH: operand A, sampled with `start`.
- `dataB`  in  WIDTH: operand B or shift amount, sampled with `start`.
- `busy`  out  1: high from the accepting edge until the edge that ends DONE.
- `done`  out  1: one-cycle pulse; outputs are valid from this cycle on.
- `dataC`  out  WIDTH: registered result.
- `zero`  out  1: high when `dataC`==0.
- `overflow`  out  1: carry, borrow or product overflow.
- `error`  out  1: `overflow` OR divide-by-zero OR illegal opcode.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset enters IDLE and sets every output to 0.
- IDLE with `start`=1:
  - opA, opB and op are latched.
  - Single-cycle opcodes go to DONE.
  - 00100/00101 go to MUL; 00110/00111/01000 go to DIV.
  - Both MUL and DIV load a WIDTH-step counter.
- MUL: one shift-add step per cycle on a 2·WIDTH accumulator. After WIDTH steps, go to DONE.
- DIV: one restoring step per cycle on the remainder/quotient registers. After WIDTH steps, go to DONE.
- DONE: registers the outputs, pulses `done`, returns to IDLE.
- Opcode semantics (all unsigned):
  - 00000/00001 add: `dataC` = (A+B) mod 2^WIDTH; `overflow` = carry out.
  - 00010/00011 sub: `dataC` = (A−B) mod 2^WIDTH; `overflow` = borrow (A<B).
  - 00100/00101 mul: `dataC` = low WIDTH bits of the product; `overflow` = upper WIDTH bits ≠ 0.
  - 00110/00111 div: `dataC` = A/B.
  - 01000 mod: `dataC` = A%B.
  - 01001/01010 slt: `dataC` = A<B.
  - 10010/10011 sgt: `dataC` = A>B.
  - 01011/01100 and; 01101/01110 or; 01111 not A.
  - 10000 shift right: logical A>>B.
  - 10001 shift left: A<<B.
  - Shifts give 0 when B ≥ WIDTH.
- Divide or mod with B=0: bypasses DIV and goes straight to DONE with `dataC`=0, `error`=1, `overflow`=0.
- Illegal opcodes 10100–11111: 1-cycle path, `dataC`=0, `error`=1, `overflow`=0.
- `overflow` is 0 for every opcode except add, sub and mul.
- `zero` is computed from the final registered `dataC`.

## Timing
- Accept edge is the rising edge with `start`=1 and `busy`=0.
- Single-cycle ops (including div0 and illegal opcodes): `done` is high in the cycle after the accept edge. Latency is 1.
- Mul, div, mod: `done` is high WIDTH+1 cycles after the accept edge.
- `busy` rises on the accept edge and falls at the edge that ends DONE. It is therefore low during the cycle after `done`.
- The earliest back-to-back `start` is accepted one cycle after `done`.
- `start` while `busy`=1 is ignored: no queuing, no effect on the operation in flight.
- Input changes after the accept edge have no effect on the operation in flight.
- `dataC`, `zero`, `overflow` and `error` hold their values until the next DONE.
- `reset` mid-operation: immediate return to IDLE, all outputs 0, no `done` pulse.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: MUL and DIV states are built as described above.
- `ALU_SEQ_MULDIV_EN` undefined:
  - MUL/DIV datapaths and states are removed.
  - Opcodes 00100–01000 take the 1-cycle path with `dataC`=0, `error`=1, `overflow`=0, exactly like illegal opcodes.

## Test plan
All scenarios use WIDTH=32 and `ALU_SEQ_MULDIV_EN` defined unless stated.
- Add overflow: add 0xFFFFFFFF+1 → `done` 1 cycle later, `dataC`=0, `zero`=1, `overflow`=1, `error`=1.
- Multiply latency and overflow:
  - mul 0x10000×0x10000 → `done` at cycle 33, `dataC`=0, `overflow`=1.
  - mul 7×6 → `dataC`=42, `overflow`=0, `error`=0.
- Division:
  - div 100/7 → `dataC`=14 at cycle 33.
  - mod 100%7 → `dataC`=2.
  - div 5/0 → `done` at cycle 1, `dataC`=0, `error`=1.
- Shifts and illegal opcode:
  - shl 1<<31 → `dataC`=0x80000000.
  - shr 0xF0>>40 → `dataC`=0, `zero`=1.
  - opCode 10111 → `error`=1.
- Handshake and reset:
  - `start` pulses during a mul are ignored; the result equals the first operands' product.
  - Asserting `reset` at cycle 10 of a div → `busy`=0, all outputs 0, no `done` pulse.
- Macro undefined: mul 7×6 → `done` at cycle 1, `dataC`=0, `error`=1.
